result_checker: RTL and testbench
=================================

# result_checker

Synthesizable response checker for TinyRISC-V block-level and FPGA self-test. It consumes the DUT output stream over a valid/ready handshake and compares each word against an expected-value ROM. It counts passes and failures, captures the first mismatch, and raises done after DEPTH words. It replaces simulation-only compare loops so the same check runs on silicon/FPGA.

## Interface
- N, 32, data word width
- DEPTH, 10, number of words checked per run (≥2)
- AW, $clog2(DEPTH), ROM address / index width
- CW, $clog2(DEPTH+1), counter width
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; begins a run from IDLE or DONE
- data_i  input  N  DUT output word
- valid_i  input  1  data_i valid
- ready_o  output  1  checker accepts data_i this cycle
- exp_addr_o  output  AW  expected-ROM address (registered)
- exp_data_i  input  N  expected-ROM data, synchronous ROM, 1-cycle read latency
- busy_o  output  1  run in progress
- done_o  output  1  run complete, held until next start
- pass_cnt_o  output  CW  matching words this run
- fail_cnt_o  output  CW  mismatching words this run
- err_o  output  1  sticky: at least one mismatch this run
- err_idx_o  output  AW  index of first mismatch
- err_got_o  output  N  data_i at first mismatch
- err_exp_o  output  N  expected value at first mismatch

## Operation
- Reset: state IDLE, idx 0. exp_addr_o, counters, err_* and all flags are 0. ready_o is 0.
- States:
  - IDLE: waits for start.
  - FETCH: one cycle; lets the ROM return the word at exp_addr_o.
  - CMP: ready_o=1; waits for valid_i.
  - DONE: done_o=1.
- IDLE/DONE + start → FETCH:
  - idx, exp_addr_o, pass_cnt_o, fail_cnt_o, err_o, err_idx_o, err_got_o and err_exp_o all clear to 0.
  - done_o clears.
- FETCH → CMP unconditionally.
- CMP with valid_i=1 (handshake):
  - Compare data_i against exp_data_i with exact equality over all N bits.
  - Match: pass_cnt_o+1. Mismatch: fail_cnt_o+1.
  - First mismatch only (err_o was 0): err_o←1, err_idx_o←idx, err_got_o←data_i, err_exp_o←exp_data_i.
  - If idx==DEPTH-1 → DONE. Otherwise idx+1, exp_addr_o←idx+1, → FETCH.
- CMP with valid_i=0: hold all state; ready_o stays 1.
- busy_o=1 in FETCH and CMP only.
- start while busy: ignored.
- Counters never exceed DEPTH and never wrap. pass_cnt_o+fail_cnt_o==DEPTH in DONE.
- valid_i while ready_o=0 (IDLE, FETCH, DONE): no transfer. The word is not counted, and no flag or state change occurs.
- Results (counters, err_*) hold stable in DONE until the next start.
- rst asserted mid-run: immediate return to reset values. No partial results are retained.

## Timing
- All outputs are registered except ready_o, which is decoded from state.
- start sampled at edge 0 → FETCH during cycle 1 → CMP (ready_o=1) from cycle 2.
- Exp ROM:
  - exp_addr_o changes at the edge leaving CMP.
  - exp_data_i must be valid from the following edge and held while exp_addr_o is unchanged.
- Throughput: at most one word per 2 cycles (FETCH+CMP per word).
- Handshake edge: counter and err_* updates are visible the cycle after the edge where valid_i&ready_o=1.
- done_o rises the cycle after the last handshake.
- Minimum run length with valid_i tied high: 2·DEPTH+1 cycles from start to done_o.

## Test plan
- All match:
  - Stimulus: ROM = i+1, DUT stream 1..10, valid_i tied high.
  - Required: done_o at cycle 21 after start, pass_cnt_o=10, fail_cnt_o=0, err_o=0.
- Single mismatch:
  - Stimulus: word 3 sent as 32'hDEAD_BEEF, expected 32'h4.
  - Required: fail_cnt_o=1, pass_cnt_o=9, err_idx_o=3, err_got_o=32'hDEADBEEF, err_exp_o=32'h4.
- Two mismatches:
  - Stimulus: mismatches at idx 2 and idx 7.
  - Required: fail_cnt_o=2, err_idx_o=2; err_* unchanged by idx 7.
- Handshake gaps:
  - Stimulus: valid_i toggled randomly, with pulses during FETCH.
  - Required: exactly 10 words counted, each compared against the correct index, results identical to the all-match case.
- start handling:
  - Stimulus: start pulsed in CMP at idx 4.
  - Required: ignored, run continues to pass_cnt_o=10.
  - Stimulus: start pulsed in DONE.
  - Required: counters/err_*/done_o clear, exp_addr_o=0, FETCH next cycle.
- Reset mid-run:
  - Stimulus: rst asserted at idx 5 (mid-run).
  - Required: same cycle, asynchronously, all outputs 0 and state IDLE. A subsequent start runs a clean full pass.

Source files
------------

// File: rtl/result_checker.sv
// result_checker: compares a valid/ready word stream against a synchronous expected-value ROM
// Ports: clk, rst (async, active-high); start pulse; data_i/valid_i/ready_o stream in;
// exp_addr_o/exp_data_i expected ROM (1-cycle latency); busy_o, done_o status;
// pass_cnt_o/fail_cnt_o counters; err_o/err_idx_o/err_got_o/err_exp_o first-mismatch capture.
module result_checker #(
    parameter int N     = 32,
    parameter int DEPTH = 10,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  data_i,
    input  logic          valid_i,
    output logic          ready_o,
    output logic [AW-1:0] exp_addr_o,
    input  logic [N-1:0]  exp_data_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [CW-1:0] pass_cnt_o,
    output logic [CW-1:0] fail_cnt_o,
    output logic          err_o,
    output logic [AW-1:0] err_idx_o,
    output logic [N-1:0]  err_got_o,
    output logic [N-1:0]  err_exp_o
);
    typedef enum logic [1:0] {IDLE, FETCH, CMP, DONE} state_t;
    state_t        state_q;
    logic [AW-1:0] idx_q;
    logic          hit_d;
    logic          last_d;
    assign ready_o = state_q == CMP;
    assign hit_d   = data_i == exp_data_i;
    assign last_d  = idx_q == AW'(DEPTH - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            exp_addr_o <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            pass_cnt_o <= '0;
            fail_cnt_o <= '0;
            err_o      <= 1'b0;
            err_idx_o  <= '0;
            err_got_o  <= '0;
            err_exp_o  <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: if (start) begin
                    state_q    <= FETCH;
                    idx_q      <= '0;
                    exp_addr_o <= '0;
                    busy_o     <= 1'b1;
                    done_o     <= 1'b0;
                    pass_cnt_o <= '0;
                    fail_cnt_o <= '0;
                    err_o      <= 1'b0;
                    err_idx_o  <= '0;
                    err_got_o  <= '0;
                    err_exp_o  <= '0;
                end
                FETCH: state_q <= CMP;
                CMP: if (valid_i) begin
                    pass_cnt_o <= hit_d ? pass_cnt_o + CW'(1) : pass_cnt_o;
                    fail_cnt_o <= hit_d ? fail_cnt_o : fail_cnt_o + CW'(1);
                    // only the first mismatch of a run is captured
                    if (!hit_d && !err_o) begin
                        err_o     <= 1'b1;
                        err_idx_o <= idx_q;
                        err_got_o <= data_i;
                        err_exp_o <= exp_data_i;
                    end
                    if (last_d) begin
                        state_q <= DONE;
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                    end else begin
                        state_q    <= FETCH;
                        idx_q      <= idx_q + AW'(1);
                        exp_addr_o <= idx_q + AW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_result_checker.sv
// tb_result_checker: table-driven directed checks of result_checker with a ROM and stream model
module tb_result_checker;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] data_i;
    logic        valid_i = 1'b1;
    logic        ready_o;
    logic [3:0]  exp_addr_o;
    logic [31:0] exp_data_i = '0;
    logic        busy_o, done_o, err_o;
    logic [3:0]  pass_cnt_o, fail_cnt_o, err_idx_o;
    logic [31:0] err_got_o, err_exp_o;

    result_checker dut (
        .clk(clk), .rst(rst), .start(start), .data_i(data_i), .valid_i(valid_i),
        .ready_o(ready_o), .exp_addr_o(exp_addr_o), .exp_data_i(exp_data_i),
        .busy_o(busy_o), .done_o(done_o), .pass_cnt_o(pass_cnt_o), .fail_cnt_o(fail_cnt_o),
        .err_o(err_o), .err_idx_o(err_idx_o), .err_got_o(err_got_o), .err_exp_o(err_exp_o)
    );

    always #5 clk = ~clk;

    logic [31:0] rom [10];
    logic [31:0] stream [10];
    int          hs_total = 0;
    int          addr_bad = 0;
    int          base = 0;
    int          widx;
    bit          gaps = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;

    always @(posedge clk) exp_data_i <= rom[exp_addr_o];

    always_comb begin
        widx = hs_total - base;
        data_i = (widx >= 0 && widx < 10) ? stream[widx] : 32'h0;
    end

    always @(negedge clk) valid_i = gaps ? 1'($urandom_range(0, 1)) : 1'b1;

    // every accepted word must be compared at the address of its own index
    always @(posedge clk)
        if (valid_i && ready_o) begin
            if (32'(exp_addr_o) != 32'(hs_total - base)) addr_bad++;
            hs_total++;
        end

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endfunction

    typedef struct {
        int          bad_a;
        logic [31:0] val_a;
        int          bad_b;
        logic [31:0] val_b;
        bit          gap;
        int          pass;
        int          fail;
        bit          err;
        int          eidx;
        logic [31:0] got;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [6];

    task automatic run(input vec_t v, input bit ign, input bit clr);
        int  n;
        int  ab;
        bit  fired;
        for (int i = 0; i < 10; i++)
            stream[i] = (i == v.bad_a) ? v.val_a : (i == v.bad_b) ? v.val_b : 32'(i + 1);
        gaps = v.gap;
        ab = addr_bad;
        fired = 1'b0;
        @(negedge clk);
        base = hs_total;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (clr) begin
            chk("clr_done", 32'(done_o), 0);
            chk("clr_pass", 32'(pass_cnt_o), 0);
            chk("clr_fail", 32'(fail_cnt_o), 0);
            chk("clr_err", 32'(err_o), 0);
            chk("clr_err_idx", 32'(err_idx_o), 0);
            chk("clr_err_got", err_got_o, 0);
            chk("clr_err_exp", err_exp_o, 0);
            chk("clr_addr", 32'(exp_addr_o), 0);
            chk("clr_fetch", {30'd0, busy_o, ready_o}, 32'h2);
        end
        n = 1;
        while (!done_o && n < 400) begin
            @(negedge clk);
            n++;
            start = ign && !fired && ready_o && exp_addr_o == 4'd4;
            if (start) fired = 1'b1;
        end
        start = 1'b0;
        gaps = 1'b0;
        chk("done_reached", 32'(done_o), 1);
        if (!v.gap) chk("done_cycle", n, 21);
        if (ign) chk("start_ign_fired", 32'(fired), 1);
        chk("words", hs_total - base, 10);
        chk("addr_per_word", addr_bad - ab, 0);
        chk("busy_done", 32'(busy_o), 0);
        chk("pass_cnt", 32'(pass_cnt_o), 32'(v.pass));
        chk("fail_cnt", 32'(fail_cnt_o), 32'(v.fail));
        chk("err", 32'(err_o), 32'(v.err));
        chk("err_idx", 32'(err_idx_o), 32'(v.eidx));
        chk("err_got", err_got_o, v.got);
        chk("err_exp", err_exp_o, v.exp);
        repeat (3) @(negedge clk);
        chk("hold_done", 32'(done_o), 1);
        chk("hold_cnt", 32'(pass_cnt_o) + 32'(fail_cnt_o), 10);
        chk("hold_pass", 32'(pass_cnt_o), 32'(v.pass));
    endtask

    initial begin
        int n;
        for (int i = 0; i < 10; i++) rom[i] = 32'(i + 1);
        vt[0] = '{-1, 32'h0, -1, 32'h0, 1'b0, 10, 0, 1'b0, 0, 32'h0, 32'h0};
        vt[1] = '{3, 32'hDEAD_BEEF, -1, 32'h0, 1'b0, 9, 1, 1'b1, 3, 32'hDEAD_BEEF, 32'h4};
        vt[2] = '{2, 32'h0, 7, 32'h1234, 1'b0, 8, 2, 1'b1, 2, 32'h0, 32'h3};
        vt[3] = '{-1, 32'h0, -1, 32'h0, 1'b1, 10, 0, 1'b0, 0, 32'h0, 32'h0};
        vt[4] = '{0, 32'hFFFF_FFFF, 9, 32'hB, 1'b0, 8, 2, 1'b1, 0, 32'hFFFF_FFFF, 32'h1};
        vt[5] = '{5, 32'h8000_0006, -1, 32'h0, 1'b0, 9, 1, 1'b1, 5, 32'h8000_0006, 32'h6};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_flags", {27'd0, ready_o, busy_o, done_o, err_o, 1'b0}, 0);
        chk("rst_addr", 32'(exp_addr_o), 0);
        chk("rst_cnt", {pass_cnt_o, fail_cnt_o, err_idx_o}, 0);
        chk("rst_err_data", err_got_o | err_exp_o, 0);
        chk("idle_no_xfer", hs_total, 0);

        for (int i = 0; i < 6; i++) run(vt[i], 1'b0, 1'b0);

        run(vt[0], 1'b1, 1'b0);
        run(vt[1], 1'b0, 1'b0);
        run(vt[0], 1'b0, 1'b1);

        for (int i = 0; i < 10; i++) stream[i] = 32'(i + 1);
        @(negedge clk);
        base = hs_total;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(ready_o && exp_addr_o == 4'd5) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("mid_reached", 32'(ready_o && exp_addr_o == 4'd5), 1);
        chk("mid_pass", 32'(pass_cnt_o), 5);
        #2 rst = 1'b1;
        #1;
        chk("arst_flags", {27'd0, ready_o, busy_o, done_o, err_o, 1'b0}, 0);
        chk("arst_addr", 32'(exp_addr_o), 0);
        chk("arst_cnt", {pass_cnt_o, fail_cnt_o, err_idx_o}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("arst_idle", {30'd0, busy_o, ready_o}, 0);
        run(vt[0], 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
